// File: rtl/alarm_pkg.sv
// Shared types and widths for the alarm sequencer (alarm_ring_ctrl, beep_gen).
// Optional snooze support is enabled by defining ALARM_SNOOZE_EN.
package alarm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RING   = 2'd1,
      SNOOZE = 2'd2
   } alarm_state_t;

   localparam int HOUR_W = 5;
   localparam int MIN_W  = 6;
   localparam int SEC_W  = 6;

   function automatic int clks_per_ms(input int clk_hz);
      return clk_hz / 1000;
   endfunction

endpackage

// File: rtl/beep_gen.sv
// Square-wave buzzer generator: high for HALF clocks, low for HALF clocks.
// Held at 0 while en is low; restarts high on the first enabled cycle.
module beep_gen #(
   parameter int HALF = 12_500_000
) (
   input  logic CLOCK_50,
   input  logic rst_n,
   input  logic en,
   output logic wave
);

   localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_run;
   logic             r_wave;

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_wave <= 1'b0;
      end else if (!en) begin
         r_cnt  <= '0;
         r_run  <= 1'b0;
         r_wave <= 1'b0;
      end else if (!r_run) begin
         r_cnt  <= '0;
         r_run  <= 1'b1;
         r_wave <= 1'b1;
      end else if (r_cnt == LAST) begin
         r_cnt  <= '0;
         r_wave <= ~r_wave;
      end else begin
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign wave = r_wave;

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm sequencer: matches time-of-day against the alarm, rings, times out and snoozes.
// Snooze (SNOOZE state, snooze counters) exists only when ALARM_SNOOZE_EN is defined.
module alarm_ring_ctrl
   import alarm_pkg::*;
#(
   parameter int CLK_HZ       = 50_000_000,
   parameter int BEEP_HALF_MS = 250,
   parameter int RING_SEC     = 60,
   parameter int SNOOZE_MIN   = 5,
   parameter int MAX_SNOOZE   = 3
) (
   input  logic              CLOCK_50,
   input  logic              rst_n,
   input  logic              tick_1hz,
   input  logic [HOUR_W-1:0] cur_hour,
   input  logic [MIN_W-1:0]  cur_min,
   input  logic [SEC_W-1:0]  cur_sec,
   input  logic [HOUR_W-1:0] alm_hour,
   input  logic [MIN_W-1:0]  alm_min,
   input  logic              adjust,
   input  logic              adjust_alarm,
   input  logic              flip_state,
   input  logic              stop_req,
   input  logic              snooze_req,
   output logic              armed,
   output logic              ringing,
   output logic              snoozing,
   output logic              buzzer
);

   localparam int HALF   = clks_per_ms(CLK_HZ) * BEEP_HALF_MS;
   localparam int RING_W = $clog2(RING_SEC + 1);
   localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_SEC - 1);

   alarm_state_t      r_state, w_state_next;
   logic              r_armed;
   logic              r_ringing;
   logic [RING_W-1:0] r_ring_cnt, w_ring_cnt_next;
   logic              w_match, w_disarm, w_ring_en;

`ifdef ALARM_SNOOZE_EN
   localparam int SZ_TICKS = SNOOZE_MIN * 60;
   localparam int SZ_W     = $clog2(SZ_TICKS + 1);
   localparam int SN_W     = (MAX_SNOOZE > 0) ? $clog2(MAX_SNOOZE + 1) : 1;
   localparam logic [SZ_W-1:0] SZ_LAST = SZ_W'(SZ_TICKS - 1);
   localparam logic [SN_W-1:0] SN_MAX  = SN_W'(MAX_SNOOZE);

   logic [SZ_W-1:0] r_sz_cnt, w_sz_cnt_next;
   logic [SN_W-1:0] r_snooze_cnt, w_snooze_cnt_next;
   logic            r_snoozing;
`else
   // Snooze inputs and parameters have no function in this build.
   logic w_unused_snooze;
   assign w_unused_snooze = snooze_req & (SNOOZE_MIN >= 0) & (MAX_SNOOZE >= 0);
`endif

   // armed is sampled before its toggle, so arming in a match cycle cannot ring.
   assign w_match  = tick_1hz & r_armed & adjust & ~adjust_alarm &
                     (cur_hour == alm_hour) & (cur_min == alm_min) & (cur_sec == '0);
   assign w_disarm = flip_state & r_armed;

   always_comb begin
      w_state_next    = r_state;
      w_ring_cnt_next = r_ring_cnt;
`ifdef ALARM_SNOOZE_EN
      w_sz_cnt_next     = r_sz_cnt;
      w_snooze_cnt_next = w_disarm ? '0 : r_snooze_cnt;
`endif
      case (r_state)
         IDLE: begin
            if (w_match && !w_disarm) begin
               w_state_next    = RING;
               w_ring_cnt_next = '0;
`ifdef ALARM_SNOOZE_EN
               w_snooze_cnt_next = '0;
`endif
            end
         end
         RING: begin
            if (w_disarm || !adjust || stop_req) begin
               w_state_next = IDLE;
`ifdef ALARM_SNOOZE_EN
            end else if (snooze_req && (r_snooze_cnt < SN_MAX)) begin
               w_state_next      = SNOOZE;
               w_sz_cnt_next     = '0;
               w_snooze_cnt_next = r_snooze_cnt + 1'b1;
            end else if (snooze_req) begin
               w_state_next = IDLE;
`endif
            end else if (tick_1hz) begin
               if (r_ring_cnt == RING_LAST) w_state_next = IDLE;
               else                         w_ring_cnt_next = r_ring_cnt + 1'b1;
            end
         end
`ifdef ALARM_SNOOZE_EN
         SNOOZE: begin
            if (w_disarm || !adjust || stop_req) begin
               w_state_next = IDLE;
            end else if (tick_1hz) begin
               if (r_sz_cnt == SZ_LAST) begin
                  w_state_next    = RING;
                  w_ring_cnt_next = '0;
               end else begin
                  w_sz_cnt_next = r_sz_cnt + 1'b1;
               end
            end
         end
`endif
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLOCK_50 or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_armed    <= 1'b0;
         r_ringing  <= 1'b0;
         r_ring_cnt <= '0;
`ifdef ALARM_SNOOZE_EN
         r_sz_cnt     <= '0;
         r_snooze_cnt <= '0;
         r_snoozing   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_armed    <= r_armed ^ flip_state;
         r_ringing  <= (w_state_next == RING);
         r_ring_cnt <= w_ring_cnt_next;
`ifdef ALARM_SNOOZE_EN
         r_sz_cnt     <= w_sz_cnt_next;
         r_snooze_cnt <= w_snooze_cnt_next;
         r_snoozing   <= (w_state_next == SNOOZE);
`endif
      end
   end

   // Driven from the next state so the buzzer rises together with ringing.
   assign w_ring_en = (w_state_next == RING);

   beep_gen #(.HALF(HALF)) u_beep (
      .CLOCK_50 (CLOCK_50),
      .rst_n    (rst_n),
      .en       (w_ring_en),
      .wave     (buzzer)
   );

   assign armed   = r_armed;
   assign ringing = r_ringing;
`ifdef ALARM_SNOOZE_EN
   assign snoozing = r_snoozing;
`else
   assign snoozing = 1'b0;
`endif

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Self-checking bench for alarm_ring_ctrl: behavioural model compared every cycle,
// plus literal checks on directed scenarios. Adapts to ALARM_SNOOZE_EN.
module tb_alarm_ring_ctrl;
   import alarm_pkg::*;

   localparam int CLK_HZ = 1000, BEEP_HALF_MS = 2, RING_SEC = 3, SNOOZE_MIN = 1, MAX_SNOOZE = 1;
   localparam int HALF = 2;
`ifdef ALARM_SNOOZE_EN
   localparam bit SNZ_EN = 1'b1;
`else
   localparam bit SNZ_EN = 1'b0;
`endif

   logic CLOCK_50 = 1'b0, rst_n = 1'b0, tick_1hz = 1'b0;
   logic [HOUR_W-1:0] cur_hour = 5'd7, alm_hour = 5'd7;
   logic [MIN_W-1:0]  cur_min = 6'd30, alm_min = 6'd30;
   logic [SEC_W-1:0]  cur_sec = 6'd1;
   logic adjust = 1'b1, adjust_alarm = 1'b0, flip_state = 1'b0, stop_req = 1'b0, snooze_req = 1'b0;
   logic armed, ringing, snoozing, buzzer;

   alarm_ring_ctrl #(.CLK_HZ(CLK_HZ), .BEEP_HALF_MS(BEEP_HALF_MS), .RING_SEC(RING_SEC),
                     .SNOOZE_MIN(SNOOZE_MIN), .MAX_SNOOZE(MAX_SNOOZE)) dut (
      .CLOCK_50(CLOCK_50), .rst_n(rst_n), .tick_1hz(tick_1hz),
      .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
      .alm_hour(alm_hour), .alm_min(alm_min),
      .adjust(adjust), .adjust_alarm(adjust_alarm),
      .flip_state(flip_state), .stop_req(stop_req), .snooze_req(snooze_req),
      .armed(armed), .ringing(ringing), .snoozing(snoozing), .buzzer(buzzer)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   int n_vec = 0, n_miss = 0;
   bit chk_en = 1'b0;

   // Model: mode 0 idle, 1 ring, 2 snooze; buzzer derived from time since ring entry.
   int m_mode = 0, m_ring_ticks = 0, m_sz_ticks = 0, m_snoozes = 0, m_cyc = 0, m_ring_start = 0;
   bit m_armed = 1'b0;

   task automatic model_reset();
      m_mode = 0; m_armed = 1'b0; m_ring_ticks = 0; m_sz_ticks = 0; m_snoozes = 0;
   endtask

   task automatic enter_ring();
      m_mode = 1; m_ring_ticks = 0; m_ring_start = m_cyc;
   endtask

   task automatic model_step();
      bit disarm, match;
      disarm = flip_state && m_armed;
      match  = tick_1hz && m_armed && adjust && !adjust_alarm &&
               cur_hour == alm_hour && cur_min == alm_min && cur_sec == 0;
      m_armed = m_armed ^ flip_state;
      if (disarm) m_snoozes = 0;
      if (m_mode == 0) begin
         if (match && !disarm) begin enter_ring(); m_snoozes = 0; end
      end else if (disarm || !adjust || stop_req) begin
         m_mode = 0;
      end else if (m_mode == 1) begin
         if (SNZ_EN && snooze_req) begin
            if (m_snoozes < MAX_SNOOZE) begin m_mode = 2; m_sz_ticks = 0; m_snoozes++; end
            else m_mode = 0;
         end else if (tick_1hz) begin
            m_ring_ticks++;
            if (m_ring_ticks == RING_SEC) m_mode = 0;
         end
      end else if (tick_1hz) begin
         m_sz_ticks++;
         if (m_sz_ticks == SNOOZE_MIN * 60) enter_ring();
      end
      m_cyc++;
   endtask

   function automatic bit exp_buzzer();
      return (m_mode == 1) && ((((m_cyc - m_ring_start - 1) / HALF) % 2) == 0);
   endfunction

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(posedge CLOCK_50 or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
   end

   initial forever begin
      @(negedge CLOCK_50);
      if (chk_en) begin
         check("armed", armed, m_armed);
         check("ringing", ringing, m_mode == 1);
         check("snoozing", snoozing, m_mode == 2);
         check("buzzer", buzzer, exp_buzzer());
      end
   end

   task automatic cyc(input bit t, input bit f, input bit s, input bit z);
      tick_1hz = t; flip_state = f; stop_req = s; snooze_req = z;
      @(negedge CLOCK_50); #2;
   endtask

   task automatic match_tick();
      cur_hour = alm_hour; cur_min = alm_min; cur_sec = 6'd0;
      cyc(1, 0, 0, 0);
      cur_sec = 6'd1;
   endtask

   initial begin
      @(negedge CLOCK_50); #2;
      repeat (3) cyc(0, 0, 0, 0);
      $display("reset held");
      check("rst_armed", armed, 1'b0);
      check("rst_ringing", ringing, 1'b0);
      check("rst_snoozing", snoozing, 1'b0);
      check("rst_buzzer", buzzer, 1'b0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0);
      chk_en = 1'b1;

      $display("arm and ring at 07:30:00");
      cyc(0, 1, 0, 0);
      check("arm", armed, 1'b1);
      match_tick();
      check("ring_on", ringing, 1'b1);
      check("buzz_e0", buzzer, 1'b1);
      cyc(0, 0, 0, 0); check("buzz_e1", buzzer, 1'b1);
      cyc(0, 0, 0, 0); check("buzz_e2", buzzer, 1'b0);
      cyc(0, 0, 0, 0); check("buzz_e3", buzzer, 1'b0);
      cyc(0, 0, 0, 0); check("buzz_e4", buzzer, 1'b1);

      $display("ring timeout after %0d ticks", RING_SEC);
      cyc(1, 0, 0, 0); cyc(1, 0, 0, 0);
      check("ring_tick2", ringing, 1'b1);
      cyc(1, 0, 0, 0);
      check("timeout_ring", ringing, 1'b0);
      check("timeout_buzz", buzzer, 1'b0);

      $display("snooze sequence");
      match_tick();
      cyc(0, 0, 0, 1);
      if (SNZ_EN) begin
         check("snz_on", snoozing, 1'b1);
         check("snz_buzz", buzzer, 1'b0);
         repeat (SNOOZE_MIN * 60 - 1) cyc(1, 0, 0, 0);
         check("snz_hold", snoozing, 1'b1);
         cyc(1, 0, 0, 0);
         check("snz_back", ringing, 1'b1);
         check("snz_back_buzz", buzzer, 1'b1);
         cyc(0, 0, 0, 1);
         check("snz_max_stop", ringing, 1'b0);
         check("snz_max_snz", snoozing, 1'b0);
      end else begin
         check("snz_ignored", ringing, 1'b1);
         check("snz_tied0", snoozing, 1'b0);
         cyc(0, 0, 1, 0);
         check("stop_ring", ringing, 1'b0);
      end

      $display("stop and snooze together");
      match_tick();
      cyc(0, 0, 1, 1);
      check("stopsnz_ring", ringing, 1'b0);
      check("stopsnz_snz", snoozing, 1'b0);

      $display("blocked matches");
      adjust = 1'b0; match_tick(); check("adj0_idle", ringing, 1'b0); adjust = 1'b1;
      adjust_alarm = 1'b1; match_tick(); check("adjalm_idle", ringing, 1'b0); adjust_alarm = 1'b0;
      cyc(0, 1, 0, 0); check("disarm", armed, 1'b0);
      match_tick(); check("disarmed_idle", ringing, 1'b0);
      cur_sec = 6'd0; cyc(1, 1, 0, 0); cur_sec = 6'd1;
      check("arm_on_match", armed, 1'b1);
      check("arm_on_match_idle", ringing, 1'b0);

      $display("disarm and time-set during ring");
      match_tick();
      cyc(0, 1, 0, 0);
      check("flip_armed", armed, 1'b0);
      check("flip_ring", ringing, 1'b0);
      check("flip_buzz", buzzer, 1'b0);
      cyc(0, 1, 0, 0);
      match_tick();
      adjust = 1'b0; cyc(0, 0, 0, 0); adjust = 1'b1;
      check("adjfall_ring", ringing, 1'b0);

      $display("random phase");
      for (int i = 0; i < 3000; i++) begin
         adjust       = ($urandom_range(0, 49) != 0);
         adjust_alarm = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 1) == 1) begin
            cur_hour = alm_hour; cur_min = alm_min; cur_sec = 6'd0;
         end else begin
            cur_hour = 5'($urandom_range(0, 23));
            cur_min  = 6'($urandom_range(0, 59));
            cur_sec  = 6'($urandom_range(0, 59));
         end
         cyc($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
             $urandom_range(0, 29) == 0, $urandom_range(0, 14) == 0);
      end

      $display("async reset mid-ring");
      adjust = 1'b1; adjust_alarm = 1'b0; cur_sec = 6'd1;
      cyc(0, 0, 1, 0);
      if (!m_armed) cyc(0, 1, 0, 0);
      match_tick();
      check("pre_rst_ring", ringing, 1'b1);
      cyc(0, 0, 0, 0);
      rst_n = 1'b0;
      #1;
      check("arst_armed", armed, 1'b0);
      check("arst_ringing", ringing, 1'b0);
      check("arst_snoozing", snoozing, 1'b0);
      check("arst_buzzer", buzzer, 1'b0);
      #1;
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);
      rst_n = 1'b1;
      cyc(0, 0, 0, 0); cyc(0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
